// File: rtl/jtag_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// jtag_scan_sequencer_if
// Host-side command/response bundle for jtag_scan_sequencer.
//   cmd_valid/cmd_ready  command handshake, transfer at posedge when both high
//   cmd_op               0=TAP reset, 1=IR scan, 2=DR scan, 3=idle wait
//   cmd_len              scan length (ops 1/2) or idle cycle count (op 3)
//   cmd_data             TDI bits, LSB shifted first
//   rsp_valid/rsp_err    one-cycle completion pulse, err qualifies a rejection
//   rsp_data             captured TDO, bit k = k-th shifted bit
//   busy                 inverse of cmd_ready
// master = host side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface jtag_scan_sequencer_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_err;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_err, rsp_data, busy
  );
endinterface

// File: rtl/jtag_scan_sequencer.sv
// ---------------------------------------------------------------------------
// jtag_scan_sequencer
// Command-driven JTAG master. Walks the TAP from Run-Test/Idle through reset,
// IR-scan, DR-scan or idle-wait sequences by driving TMS/TDI each tck, and
// captures TDO from the shift cycles into a response word.
// Ports:
//   tck    clock, all state changes on posedge
//   trst   asynchronous active-low reset (reruns the TAP auto-reset on release)
//   bus    command/response bundle (slave modport of jtag_scan_sequencer_if)
//   tms_o  TMS to the TAP
//   tdi_o  TDI to the TAP
//   tdo_i  TDO from the TAP scan chain
// ---------------------------------------------------------------------------
module jtag_scan_sequencer #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic                   tck,
  input  logic                   trst,
  jtag_scan_sequencer_if.slave   bus,
  output logic                   tms_o,
  output logic                   tdi_o,
  input  logic                   tdo_i
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W:0] MAX_LEN_C = (LEN_W+1)'(MAX_LEN);

  localparam logic [1:0] OP_RST  = 2'd0;
  localparam logic [1:0] OP_IR   = 2'd1;
  localparam logic [1:0] OP_DR   = 2'd2;

  localparam logic [3:0] ST_INIT_RST = 4'd0;
  localparam logic [3:0] ST_READY    = 4'd1;
  localparam logic [3:0] ST_RST5     = 4'd2;
  localparam logic [3:0] ST_SEL_DR   = 4'd3;
  localparam logic [3:0] ST_SEL_IR   = 4'd4;
  localparam logic [3:0] ST_CAPTURE  = 4'd5;
  localparam logic [3:0] ST_SHIFT    = 4'd6;
  localparam logic [3:0] ST_EXIT1    = 4'd7;
  localparam logic [3:0] ST_UPDATE   = 4'd8;
  localparam logic [3:0] ST_WAIT     = 4'd9;
  localparam logic [3:0] ST_ERR      = 4'd10;

  logic [3:0]         state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_valid, rsp_err;
  logic [IDX_W-1:0]   idx;
  logic               len_bad;
  logic               wait_last;

  assign idx       = cnt_q[IDX_W-1:0];
  assign len_bad   = (bus.cmd_len == '0) || ({1'b0, bus.cmd_len} > MAX_LEN_C);
  // Idle wait of N=0 still spends one cycle, so "last" is cnt+1 >= N.
  assign wait_last = (cnt_q + LEN_W'(1)) >= len_q;

  assign bus.cmd_ready = (state_q == ST_READY);
  assign bus.busy      = (state_q != ST_READY);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_data  = rsp_data_q;

  // Next-state and TMS/TDI decode. Every state is one or more tck cycles of a
  // TMS value; the five-ones reset walk is shared by auto-reset and op 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    len_d      = len_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    tms_o      = 1'b0;
    tdi_o      = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    case (state_q)
      ST_INIT_RST, ST_RST5: begin
        tms_o = (cnt_q != LEN_W'(5));
        if (cnt_q == LEN_W'(5)) begin
          rsp_valid = (state_q == ST_RST5);
          state_d   = ST_READY;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      ST_READY: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          len_d  = bus.cmd_len;
          data_d = bus.cmd_data;
          cnt_d  = '0;
          case (bus.cmd_op)
            OP_RST: state_d = ST_RST5;
            OP_IR, OP_DR: begin
              if (len_bad) begin
                state_d = ST_ERR;
              end else begin
                state_d    = ST_SEL_DR;
                rsp_data_d = '0;
              end
            end
            default: state_d = ST_WAIT;
          endcase
        end
      end
      ST_SEL_DR: begin
        tms_o   = 1'b1;
        state_d = (op_q == OP_IR) ? ST_SEL_IR : ST_CAPTURE;
      end
      ST_SEL_IR: begin
        tms_o   = 1'b1;
        state_d = ST_CAPTURE;
      end
      // Two TMS=0 cycles: enter Capture, then enter Shift.
      ST_CAPTURE: begin
        if (cnt_q == LEN_W'(1)) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      // TMS rises in the last shift cycle so the TAP leaves Shift on that edge.
      ST_SHIFT: begin
        tdi_o           = data_q[idx];
        tms_o           = (cnt_q == len_q - LEN_W'(1));
        rsp_data_d[idx] = tdo_i;
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = ST_EXIT1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      ST_EXIT1: begin
        tms_o   = 1'b1;
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        rsp_valid = 1'b1;
        state_d   = ST_READY;
      end
      ST_WAIT: begin
        if (wait_last) begin
          rsp_valid = 1'b1;
          state_d   = ST_READY;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      ST_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = ST_READY;
      end
      default: begin
        state_d = ST_INIT_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; trst drops any in-flight command and restarts auto-reset.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q    <= ST_INIT_RST;
      cnt_q      <= '0;
      op_q       <= OP_RST;
      len_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      len_q      <= len_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jtag_scan_sequencer
// Directed plus randomized checks of jtag_scan_sequencer. Expected TMS/TDI
// sequences and response words come from a list-based model of the command
// rules (what each op emits cycle by cycle), not from the RTL state machine.
// ---------------------------------------------------------------------------
module tb_jtag_scan_sequencer;

  logic tck;
  logic trst;
  logic tmsO;
  logic tdiO;
  logic tdoI;

  int checks;
  int passed;
  logic [31:0] expRsp;

  jtag_scan_sequencer_if bus ();

  jtag_scan_sequencer dut (
    .tck   (tck),
    .trst  (trst),
    .bus   (bus.slave),
    .tms_o (tmsO),
    .tdi_o (tdiO),
    .tdo_i (tdoI)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // Hard time limit so a stuck design still ends with a report.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_tms"}, 128'(tmsO), 128'(1));
    checkOutput({tag, "_tdi"}, 128'(tdiO), 128'(0));
    checkOutput({tag, "_ready"}, 128'(bus.cmd_ready), 128'(0));
    checkOutput({tag, "_busy"}, 128'(bus.busy), 128'(1));
    checkOutput({tag, "_rspv"}, 128'(bus.rsp_valid), 128'(0));
    checkOutput({tag, "_rsperr"}, 128'(bus.rsp_err), 128'(0));
    checkOutput({tag, "_rspdata"}, 128'(bus.rsp_data), 128'(0));
  endtask

  // Called at the negedge where trst was just released.
  task automatic checkAutoReset(input string tag);
    logic [127:0] oT, oV, oB;
    oT = '0; oV = '0; oB = '0;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge tck);
      oT[i] = tmsO;
      oV[i] = bus.rsp_valid;
      oB[i] = bus.busy;
    end
    @(negedge tck);
    checkOutput({tag, "_tms_seq"}, oT, 128'b011111);
    checkOutput({tag, "_no_rspv"}, oV, 128'(0));
    checkOutput({tag, "_busy_seq"}, oB, 128'b111111);
    checkOutput({tag, "_ready7"}, 128'(bus.cmd_ready), 128'(1));
  endtask

  // Waits (bounded) for cmd_ready at a negedge and presents a command.
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] len,
                               input logic [31:0] data, output bit ok);
    int budget;
    budget = 0;
    while (bus.cmd_ready !== 1'b1 && budget < 100) begin
      @(negedge tck);
      budget++;
    end
    ok = (bus.cmd_ready === 1'b1);
    if (!ok) begin
      checkOutput("ready_wait", 128'(bus.cmd_ready), 128'(1));
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
  endtask

  // One command end to end against the reference model.
  task automatic runOp(input string tag, input logic [1:0] op, input logic [5:0] len,
                       input logic [31:0] data, input logic [31:0] tdoPat, input bit useTdo);
    bit expTms[$];
    bit expTdi[$];
    int shiftK[$];
    logic [127:0] oT, eT, oD, eD, oV, eV, oB, eB;
    logic [31:0] newRsp, rspAtEnd;
    logic errAtEnd;
    bit err, ok, b;
    int n;

    err = (op == 2'd1 || op == 2'd2) && (len == 6'd0 || len > 6'd32);
    if (err) begin
      expTms.push_back(1'b0); expTdi.push_back(1'b0); shiftK.push_back(-1);
    end else if (op == 2'd0) begin
      for (int i = 0; i < 6; i++) begin
        expTms.push_back(i != 5); expTdi.push_back(1'b0); shiftK.push_back(-1);
      end
    end else if (op == 2'd3) begin
      for (int i = 0; i < ((len == 6'd0) ? 1 : int'(len)); i++) begin
        expTms.push_back(1'b0); expTdi.push_back(1'b0); shiftK.push_back(-1);
      end
    end else begin
      expTms.push_back(1'b1); expTdi.push_back(1'b0); shiftK.push_back(-1);
      if (op == 2'd1) begin
        expTms.push_back(1'b1); expTdi.push_back(1'b0); shiftK.push_back(-1);
      end
      for (int i = 0; i < 2; i++) begin
        expTms.push_back(1'b0); expTdi.push_back(1'b0); shiftK.push_back(-1);
      end
      for (int k = 0; k < int'(len); k++) begin
        expTms.push_back(k == int'(len) - 1); expTdi.push_back(data[k]); shiftK.push_back(k);
      end
      expTms.push_back(1'b1); expTdi.push_back(1'b0); shiftK.push_back(-1);
      expTms.push_back(1'b0); expTdi.push_back(1'b0); shiftK.push_back(-1);
    end
    n = expTms.size();

    applyStimulus(op, len, data, ok);
    if (!ok) return;
    @(posedge tck);
    @(negedge tck);

    oT = '0; eT = '0; oD = '0; eD = '0; oV = '0; eV = '0; oB = '0; eB = '0;
    newRsp = '0; rspAtEnd = '0; errAtEnd = 1'b0;
    for (int i = 0; i < n; i++) begin
      oT[i] = tmsO;  eT[i] = expTms[i];
      oD[i] = tdiO;  eD[i] = expTdi[i];
      oV[i] = bus.rsp_valid; eV[i] = (i == n - 1);
      oB[i] = bus.busy;      eB[i] = 1'b1;
      if (i == n - 1) begin
        rspAtEnd = bus.rsp_data;
        errAtEnd = bus.rsp_err;
      end
      b = 1'($urandom);
      if (shiftK[i] >= 0) begin
        if (useTdo) b = tdoPat[shiftK[i]];
        newRsp[shiftK[i]] = b;
      end
      tdoI = b;
      // Commands offered while busy must be ignored.
      bus.cmd_valid = 1'($urandom);
      bus.cmd_op    = 2'($urandom);
      bus.cmd_len   = 6'($urandom);
      bus.cmd_data  = $urandom;
      @(negedge tck);
    end
    bus.cmd_valid = 1'b0;

    if (!err && (op == 2'd1 || op == 2'd2)) expRsp = newRsp;

    checkOutput({tag, "_tms"}, oT, eT);
    checkOutput({tag, "_tdi"}, oD, eD);
    checkOutput({tag, "_rspv"}, oV, eV);
    checkOutput({tag, "_busy"}, oB, eB);
    checkOutput({tag, "_rsperr"}, 128'(errAtEnd), 128'(err));
    checkOutput({tag, "_rspdata"}, 128'(rspAtEnd), 128'(expRsp));
    checkOutput({tag, "_ready_after"}, 128'(bus.cmd_ready), 128'(1));
    checkOutput({tag, "_rspv_after"}, 128'(bus.rsp_valid), 128'(0));
    checkOutput({tag, "_held"}, 128'(bus.rsp_data), 128'(expRsp));
  endtask

  // 32-bit DR scan aborted by trst in shift cycle 10.
  task automatic trstMidShift();
    logic [127:0] oV;
    bit ok;
    applyStimulus(2'd2, 6'd32, $urandom, ok);
    if (!ok) return;
    @(posedge tck);
    @(negedge tck);
    bus.cmd_valid = 1'b0;
    oV = '0;
    for (int i = 0; i < 13; i++) begin
      oV[i] = bus.rsp_valid;
      tdoI = 1'($urandom);
      @(negedge tck);
    end
    checkOutput("t5_shift10_tms", 128'(tmsO), 128'(0));
    trst = 1'b0;
    #1;
    checkResetValues("t5_abort");
    expRsp = '0;
    repeat (3) begin
      @(negedge tck);
      oV[13] = oV[13] | bus.rsp_valid;
    end
    checkOutput("t5_no_rspv", oV, 128'(0));
    trst = 1'b1;
    checkAutoReset("t5_autorst");
  endtask

  initial begin
    checks = 0;
    passed = 0;
    expRsp = '0;
    trst = 1'b0;
    tdoI = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;

    // T1: reset values and auto-reset walk
    repeat (3) @(negedge tck);
    checkResetValues("t1_reset");
    trst = 1'b1;
    checkAutoReset("t1_autorst");

    // T2: IR scan L=4
    runOp("t2_ir4", 2'd1, 6'd4, 32'hA, 32'hB, 1'b1);
    checkOutput("t2_value", 128'(expRsp), 128'(32'h0000000B));

    // T3: full-width DR scan
    runOp("t3_dr32", 2'd2, 6'd32, 32'hDEADBEEF, 32'h12345678, 1'b1);

    // T4: rejected lengths
    runOp("t4_len0", 2'd2, 6'd0, $urandom, 32'h0, 1'b0);
    runOp("t4_len33", 2'd2, 6'd33, $urandom, 32'h0, 1'b0);
    runOp("t4_ir_len40", 2'd1, 6'd40, $urandom, 32'h0, 1'b0);

    // T6: back-to-back idle wait then TAP reset, and zero-length wait
    runOp("t6_wait3", 2'd3, 6'd3, $urandom, 32'h0, 1'b0);
    runOp("t6_rst", 2'd0, 6'($urandom), $urandom, 32'h0, 1'b0);
    runOp("t6_wait0", 2'd3, 6'd0, $urandom, 32'h0, 1'b0);
    runOp("t6_ir1", 2'd1, 6'd1, $urandom, 32'h0, 1'b0);

    // T5: trst during shift
    trstMidShift();
    runOp("t5_after", 2'd2, 6'd8, $urandom, 32'h0, 1'b0);

    // Randomized commands
    for (int r = 0; r < 40; r++) begin
      logic [1:0] op;
      logic [5:0] len;
      op = 2'($urandom_range(0, 3));
      if (op == 2'd3) len = 6'($urandom_range(0, 9));
      else            len = 6'($urandom_range(0, 34));
      runOp("rand", op, len, $urandom, 32'h0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
